// File: rtl/ddr2_ex_lfsr8_checker_pkg.sv
// Shared definitions for the DDR2 example read-side LFSR checker:
// FSM encoding, the x^8+x^4+x^3+x^2+1 step function and per-lane seeds.
package ddr2_ex_lfsr8_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
      return {s[6], s[5], s[4], s[3] ^ s[7], s[2] ^ s[7], s[1] ^ s[7], s[0], s[7]};
   endfunction

   // Lane i starts at the base seed's low byte plus i, wrapping modulo 256.
   function automatic logic [7:0] seed_of(input logic [31:0] seed, input int unsigned i);
      logic [7:0] r;
      r = seed[7:0] + i[7:0];
      return r;
   endfunction

endpackage

// File: rtl/ddr2_ex_lfsr8_lane.sv
// One byte lane of expected read data: seed load, load-from-data (self-sync)
// and single-step advance, plus a combinational match against the read byte.
module ddr2_ex_lfsr8_lane
   import ddr2_ex_lfsr8_checker_pkg::*;
#(
   parameter logic [7:0] LANE_SEED = 8'h20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load_seed,
   input  logic       load_data,
   input  logic       advance,
   input  logic [7:0] data,
   output logic [7:0] exp_data,
   output logic       match
);

   always_ff @(posedge clk) begin
      if (!reset_n)
         exp_data <= LANE_SEED;
      else if (load_seed)
         exp_data <= LANE_SEED;
      else if (load_data)
         exp_data <= lfsr8_next(data);
      else if (advance)
         exp_data <= lfsr8_next(exp_data);
   end

   assign match = (data == exp_data);

endmodule

// File: rtl/ddr2_ex_lfsr8_checker.sv
// Read-side LFSR pattern checker: seeded or self-synchronising lock, sticky
// per-lane error flags, saturating error-beat count and first-failure capture.
//
// state | meaning
// IDLE  | waiting for start; read beats ignored
// SYNC  | self-sync: reloading from the stream until LOCK_COUNT matches in a row
// CHECK | locked; every valid beat compared, expected free-runs
// DONE  | stopped; status frozen, pass valid
module ddr2_ex_lfsr8_checker
   import ddr2_ex_lfsr8_checker_pkg::*;
#(
   parameter int unsigned SEED       = 32,
   parameter int unsigned LANES      = 4,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned ERR_CNT_W  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   lock_mode,
   input  logic                   rd_valid,
   input  logic [8*LANES-1:0]     rd_data,
   output logic                   locked,
   output logic                   done,
   output logic                   pass,
   output logic [LANES-1:0]       err_lane,
   output logic [ERR_CNT_W-1:0]   err_count,
   output logic [8*LANES-1:0]     first_err_data,
   output logic [8*LANES-1:0]     first_err_exp
);

   localparam logic [7:0]           LOCK_LAST = 8'(LOCK_COUNT - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

   state_t                 state;
   logic [7:0]             match_cnt;
   logic                   sync_loaded;
   logic                   lock_seen;

   logic [LANES-1:0]       match_vec;
   logic [8*LANES-1:0]     exp_bus;
   logic                   all_match;
   logic                   beat_ok;
   logic                   sync_beat;
   logic                   check_beat;
   logic                   sync_reload;
   logic                   sync_lock;
   logic                   check_err;
   logic                   lane_load_seed;
   logic                   lane_advance;
   logic [ERR_CNT_W-1:0]   err_cnt_nxt;

   // A start cycle never consumes a beat; enable low discards it as well.
   assign beat_ok        = enable && !start && rd_valid;
   assign sync_beat      = beat_ok && (state == ST_SYNC);
   assign check_beat     = beat_ok && (state == ST_CHECK);
   assign all_match      = &match_vec;
   assign sync_reload    = sync_beat && (!sync_loaded || !all_match);
   assign sync_lock      = sync_beat && !sync_reload && (match_cnt == LOCK_LAST);
   assign check_err      = check_beat && !all_match;
   assign lane_load_seed = !enable || start;
   assign lane_advance   = check_beat || (sync_beat && !sync_reload);
   assign err_cnt_nxt    = (check_err && err_count != ERR_MAX) ? err_count + ERR_CNT_W'(1)
                                                                : err_count;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      ddr2_ex_lfsr8_lane #(
         .LANE_SEED (seed_of(32'(SEED), i))
      ) u_lane (
         .clk       (clk),
         .reset_n   (reset_n),
         .load_seed (lane_load_seed),
         .load_data (sync_reload),
         .advance   (lane_advance),
         .data      (rd_data[8*i +: 8]),
         .exp_data  (exp_bus[8*i +: 8]),
         .match     (match_vec[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         match_cnt      <= '0;
         sync_loaded    <= 1'b0;
         lock_seen      <= 1'b0;
         locked         <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_lane       <= '0;
         err_count      <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
      end else if (!enable) begin
         state     <= ST_IDLE;
         match_cnt <= '0;
         locked    <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else if (start) begin
         match_cnt      <= '0;
         sync_loaded    <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_lane       <= '0;
         err_count      <= '0;
         first_err_data <= '0;
         first_err_exp  <= '0;
         if (lock_mode) begin
            state     <= ST_SYNC;
            locked    <= 1'b0;
            lock_seen <= 1'b0;
         end else begin
            state     <= ST_CHECK;
            locked    <= 1'b1;
            lock_seen <= 1'b1;
         end
      end else begin
         case (state)
            ST_SYNC: begin
               if (sync_reload) begin
                  match_cnt   <= '0;
                  sync_loaded <= 1'b1;
               end else if (sync_lock) begin
                  state     <= ST_CHECK;
                  locked    <= 1'b1;
                  lock_seen <= 1'b1;
               end else if (sync_beat) begin
                  match_cnt <= match_cnt + 8'd1;
               end
            end
            ST_CHECK: begin
               if (check_err) begin
                  err_lane  <= err_lane | ~match_vec;
                  err_count <= err_cnt_nxt;
                  // err_count is zero only until the first bad beat since start.
                  if (err_count == '0) begin
                     first_err_data <= rd_data;
                     first_err_exp  <= exp_bus;
                  end
               end
            end
            default: ;
         endcase
         if (stop && state != ST_DONE) begin
            state  <= ST_DONE;
            locked <= 1'b0;
            done   <= 1'b1;
            pass   <= (lock_seen || sync_lock) && (err_cnt_nxt == '0);
         end
      end
   end

endmodule

// File: tb/tb_ddr2_ex_lfsr8_checker.sv
// Directed bench for the DDR2 example LFSR read checker (4 lanes, seed 0x20),
// with a second instance using a 4-bit error counter for saturation.
module tb_ddr2_ex_lfsr8_checker;

   logic        clk = 1'b0;
   logic        reset_n, enable, start, stop, lock_mode, rd_valid;
   logic [31:0] rd_data;

   logic        locked, done, pass;
   logic [3:0]  err_lane;
   logic [15:0] err_count;
   logic [31:0] first_err_data, first_err_exp;

   logic        s_locked, s_done, s_pass;
   logic [3:0]  s_err_lane;
   logic [3:0]  s_err_count;
   logic [31:0] s_first_err_data, s_first_err_exp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ddr2_ex_lfsr8_checker #(.SEED(32), .LANES(4), .LOCK_COUNT(4), .ERR_CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
      .lock_mode(lock_mode), .rd_valid(rd_valid), .rd_data(rd_data),
      .locked(locked), .done(done), .pass(pass), .err_lane(err_lane),
      .err_count(err_count), .first_err_data(first_err_data), .first_err_exp(first_err_exp)
   );

   ddr2_ex_lfsr8_checker #(.SEED(32), .LANES(4), .LOCK_COUNT(4), .ERR_CNT_W(4)) dut_sat (
      .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .stop(stop),
      .lock_mode(lock_mode), .rd_valid(rd_valid), .rd_data(rd_data),
      .locked(s_locked), .done(s_done), .pass(s_pass), .err_lane(s_err_lane),
      .err_count(s_err_count), .first_err_data(s_first_err_data), .first_err_exp(s_first_err_exp)
   );

   // Reference stream: shift-left-and-fold form of the generator polynomial.
   function automatic logic [31:0] beat_word(input int k);
      logic [7:0]  b;
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 4; i++) begin
         b = 8'h20 + 8'(i);
         for (int j = 0; j < k; j++)
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1D : 8'h00);
         w[8*i +: 8] = b;
      end
      return w;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic mode);
      lock_mode = mode;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] d);
      rd_valid = 1'b1;
      rd_data  = d;
      tick();
      rd_valid = 1'b0;
      rd_data  = 32'h0;
   endtask

   task automatic do_stop;
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
      checks++; if (err_lane !== 4'h0) begin errors++; $display("FAIL reset_err_lane got %h want 0", err_lane); end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
      checks++; if (first_err_data !== 32'h0 || first_err_exp !== 32'h0) begin
         errors++; $display("FAIL reset_first_err got %h/%h want 0/0", first_err_data, first_err_exp);
      end
   endtask

   task automatic test_seeded_clean;
      do_start(1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL seeded_locked got %b want 1", locked); end
      send(32'h23222120);
      send(32'h46444240);
      send(32'h8C888480);
      send(32'h050D151D);
      for (int k = 4; k < 8; k++) send(beat_word(k));
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL seeded_err_count got %0d want 0", err_count); end
      do_stop();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL seeded_done got %b want 1", done); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL seeded_pass got %b want 1", pass); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL seeded_locked_done got %b want 0", locked); end
   endtask

   task automatic test_single_error;
      do_start(1'b0);
      checks++; if (done !== 1'b0 || pass !== 1'b0) begin
         errors++; $display("FAIL restart_done_pass got %b/%b want 0/0", done, pass);
      end
      send(32'h23222120);
      send(32'h46444240);
      send(32'h8C888480);
      send(32'h050C151D);
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL sbe_count_latency got %0d want 1", err_count); end
      for (int k = 4; k < 8; k++) send(beat_word(k));
      checks++; if (err_lane !== 4'b0100) begin errors++; $display("FAIL sbe_err_lane got %b want 0100", err_lane); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL sbe_err_count got %0d want 1", err_count); end
      checks++; if (first_err_data !== 32'h050C151D) begin errors++; $display("FAIL sbe_first_data got %h want 050c151d", first_err_data); end
      checks++; if (first_err_exp !== 32'h050D151D) begin errors++; $display("FAIL sbe_first_exp got %h want 050d151d", first_err_exp); end
      do_stop();
      checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL sbe_pass_done got %b/%b want 0/1", pass, done); end
   endtask

   task automatic test_self_sync;
      do_start(1'b1);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_locked_start got %b want 0", locked); end
      send(beat_word(2));
      send(beat_word(3));
      send(beat_word(4));
      send(beat_word(5) ^ 32'h000000FF);
      send(beat_word(6));
      send(beat_word(7));
      send(beat_word(8));
      send(beat_word(9));
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_locked_early got %b want 0", locked); end
      send(beat_word(10));
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sync_locked_4th got %b want 1", locked); end
      send(beat_word(11));
      send(beat_word(12));
      checks++; if (err_count !== 16'd0 || err_lane !== 4'h0) begin
         errors++; $display("FAIL sync_no_errors got %0d/%b want 0/0000", err_count, err_lane);
      end
      do_stop();
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL sync_pass got %b want 1", pass); end
   endtask

   task automatic test_gapped;
      do_start(1'b0);
      for (int c = 0, k = 0; c < 8; c++) begin
         if (c % 4 == 0 || c % 4 == 3) begin
            send(beat_word(k));
            k++;
         end else begin
            rd_valid = 1'b0;
            rd_data  = 32'hDEADBEEF;
            tick();
         end
      end
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gap_err_count got %0d want 0", err_count); end
      send(32'h0A1A2A3B);
      checks++; if (err_lane !== 4'b0001) begin errors++; $display("FAIL gap_err_lane got %b want 0001", err_lane); end
      checks++; if (first_err_exp !== 32'h0A1A2A3A) begin errors++; $display("FAIL gap_first_exp got %h want 0a1a2a3a", first_err_exp); end
   endtask

   task automatic test_saturation;
      do_start(1'b0);
      for (int k = 0; k < 20; k++) send(~beat_word(k));
      checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_count got %0d want 15", s_err_count); end
      checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_wide_count got %0d want 20", err_count); end
      checks++; if (err_lane !== 4'hF) begin errors++; $display("FAIL sat_err_lane got %b want 1111", err_lane); end
      send(32'h0);
      checks++; if (s_err_count !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d want 15", s_err_count); end
   endtask

   task automatic test_reset_mid;
      do_start(1'b0);
      send(32'h11111111);
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL rst_pre_count got %0d want 1", err_count); end
      reset_n  = 1'b0;
      rd_valid = 1'b1;
      rd_data  = 32'h23222120;
      tick();
      reset_n  = 1'b1;
      rd_valid = 1'b0;
      checks++; if (err_count !== 16'd0 || err_lane !== 4'h0 || locked !== 1'b0) begin
         errors++; $display("FAIL rst_mid_status got %0d/%b/%b want 0/0000/0", err_count, err_lane, locked);
      end
      checks++; if (first_err_data !== 32'h0 || first_err_exp !== 32'h0) begin
         errors++; $display("FAIL rst_mid_first got %h/%h want 0/0", first_err_data, first_err_exp);
      end
      do_start(1'b0);
      send(32'h23222120);
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL rst_seed_restart got %0d want 0", err_count); end
   endtask

   task automatic test_enable;
      do_start(1'b0);
      send(32'h0);
      enable = 1'b0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      enable = 1'b1;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_idle_locked got %b want 0", locked); end
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL en_retain_count got %0d want 1", err_count); end
      send(32'hFFFFFFFF);
      checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL en_idle_ignore got %0d want 1", err_count); end
      do_start(1'b0);
      checks++; if (err_count !== 16'd0 || locked !== 1'b1) begin
         errors++; $display("FAIL en_restart got %0d/%b want 0/1", err_count, locked);
      end
      send(32'h23222120);
      checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL en_seed_hold got %0d want 0", err_count); end
   endtask

   task automatic test_back_to_back;
      start = 1'b1;
      stop  = 1'b1;
      lock_mode = 1'b0;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      checks++; if (locked !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL start_over_stop got %b/%b want 1/0", locked, done);
      end
      for (int k = 0; k < 6; k++) send(beat_word(k));
      do_stop();
      checks++; if (done !== 1'b1 || pass !== 1'b1) begin
         errors++; $display("FAIL b2b_done_pass got %b/%b want 1/1", done, pass);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      start     = 1'b0;
      stop      = 1'b0;
      lock_mode = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = 32'h0;
      test_reset();
      test_seeded_clean();
      test_single_error();
      test_self_sync();
      test_gapped();
      test_saturation();
      test_reset_mid();
      test_enable();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
